// File: rtl/kfpga_config_loader.sv
// kfpga_config_loader: serializes host config words LSB-first into the FPGA core config scan chain
//   clock, reset          : single clock (shared with core config_clock), synchronous active-high reset
//   start, abort          : one-cycle load request when idle/done; level abort of a running load
//   s_data/s_valid/s_ready: host configuration word stream
//   config_data/_enable/_nreset : drive of the core chain (config_in, shift enable, active-low clear)
//   busy, done, bit_count : load status and number of bits shifted in the current load
module kfpga_config_loader #(
  parameter int DATA_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 128,
  parameter int CLEAR_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  config_data,
  output logic                  config_enable,
  output logic                  config_nreset,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      bit_count
);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] clr_q, clr_d;
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      clr_q   <= clr_d;
    end
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    clr_d   = clr_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = CLEAR;
        cnt_d   = '0;
        clr_d   = '0;
      end
      CLEAR: begin
        clr_d   = clr_q + CW'(1);
        state_d = (clr_q == CW'(CLEAR_CYCLES - 1)) ? WAIT : CLEAR;
      end
      WAIT: if (s_valid) begin
        sh_d    = s_data;
        idx_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sh_d    = sh_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q + IW'(1);
        // chain completion wins over word end: leftover bits of the last word are dropped
        state_d = (cnt_d == CNT_W'(CHAIN_LENGTH)) ? DONE :
                  (idx_d == IW'(DATA_WIDTH))      ? WAIT : SHIFT;
      end
      default: state_d = IDLE;
    endcase
    // abort overrides handshake and completion; the shift counted this cycle is kept
    if (abort && busy) state_d = IDLE;
  end
  assign s_ready       = state_q == WAIT;
  assign config_enable = state_q == SHIFT;
  assign config_data   = config_enable & sh_q[0];
  assign config_nreset = state_q != CLEAR;
  assign busy          = state_q inside {CLEAR, WAIT, SHIFT};
  assign done          = state_q == DONE;
  assign bit_count     = cnt_q;
endmodule

// File: tb/tb_kfpga_config_loader.sv
// tb_kfpga_config_loader: randomized self-checking bench for a 12-bit and a 16-bit chain loader
module tb_kfpga_config_loader;
  logic clock = 0, reset = 1, start12 = 0, start16 = 0, abort = 0, s_valid = 0;
  logic [7:0] s_data = '0;
  logic r12, d12, e12, n12, b12, dn12, r16, d16, e16, n16, b16, dn16;
  logic [15:0] bc12, bc16;
  logic sel = 0;
  int checks = 0, failures = 0;
  logic [7:0] wq[$];
  logic got[$];
  int runs[$];
  int nrl, viol, rdy_after, cl;

  always #5 clock = ~clock;

  kfpga_config_loader #(.DATA_WIDTH(8), .CHAIN_LENGTH(12), .CLEAR_CYCLES(4), .CNT_W(16)) dut12 (
    .clock(clock), .reset(reset), .start(start12), .abort(abort), .s_data(s_data), .s_valid(s_valid),
    .s_ready(r12), .config_data(d12), .config_enable(e12), .config_nreset(n12),
    .busy(b12), .done(dn12), .bit_count(bc12));
  kfpga_config_loader #(.DATA_WIDTH(8), .CHAIN_LENGTH(16), .CLEAR_CYCLES(4), .CNT_W(16)) dut16 (
    .clock(clock), .reset(reset), .start(start16), .abort(abort), .s_data(s_data), .s_valid(s_valid),
    .s_ready(r16), .config_data(d16), .config_enable(e16), .config_nreset(n16),
    .busy(b16), .done(dn16), .bit_count(bc16));

  wire o_ready = sel ? r16 : r12;
  wire o_data  = sel ? d16 : d12;
  wire o_en    = sel ? e16 : e12;
  wire o_nrst  = sel ? n16 : n12;
  wire o_busy  = sel ? b16 : b12;
  wire o_done  = sel ? dn16 : dn12;
  wire [15:0] o_bc = sel ? bc16 : bc12;

  task automatic fill();
    wq = {};
    repeat ((cl + 7) / 8) wq.push_back(8'($urandom));
  endtask

  // reference: chain bit i is bit (i mod 8) of word (i div 8)
  function automatic int seq_errors();
    int e = (got.size() == cl) ? 0 : 1;
    for (int i = 0; i < got.size() && i < cl; i++) if (got[i] !== wq[i / 8][i % 8]) e++;
    return e;
  endfunction

  // drives one load cycle by cycle from the negedge; returns right after done, or one cycle after abort/reset
  task automatic run(input int gap, input bit rnd, input int ab_at, input int st_at, input int rs_at);
    int wi = 0, shifts = 0, idle = 0, rl = 0, g;
    bit stop = 0, pend = 0;
    got = {}; runs = {}; nrl = 0; viol = 0; rdy_after = 0;
    @(negedge clock);
    if (sel) start16 = 1; else start12 = 1;
    @(negedge clock);
    g = rnd ? int'($urandom_range(gap, 0)) : gap;
    for (int c = 0; c < 400 && !stop; c++) begin
      if (c != 0) @(negedge clock);
      start12 = 0; start16 = 0; s_valid = 0; s_data = 8'($urandom);
      if (pend) begin
        abort = 0; reset = 0; stop = 1;
      end else begin
        if (!o_nrst) nrl++;
        if (!o_en && o_data) viol++;
        if (o_en) begin got.push_back(o_data); rl++; shifts++; end
        else if (rl != 0) begin runs.push_back(rl); rl = 0; end
        if (o_done) stop = 1;
        if (o_ready) begin
          if (wi >= wq.size()) rdy_after++;
          else if (idle < g) idle++;
          else begin
            s_data = wq[wi]; s_valid = 1; wi++; idle = 0;
            g = rnd ? int'($urandom_range(gap, 0)) : gap;
          end
        end
        if (o_en && shifts == ab_at) begin abort = 1; pend = 1; end
        if (o_en && shifts == st_at) begin if (sel) start16 = 1; else start12 = 1; end
        if (o_en && shifts == rs_at) begin reset = 1; pend = 1; end
      end
    end
    checks++;
    if (!stop) begin
      failures++;
      $display("FAIL run_timeout: load never finished (bits=%0d), required done within 400 cycles", got.size());
      reset = 1; @(negedge clock); reset = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clock);
    checks++;
    if ({o_ready, o_data, o_en, o_nrst, o_busy, o_done} !== 6'b000100 || o_bc !== 16'd0) begin
      failures++;
      $display("FAIL reset_values: rdy,dat,en,nrst,busy,done=%b bc=%0d, required 000100 bc=0",
               {o_ready, o_data, o_en, o_nrst, o_busy, o_done}, o_bc);
    end
    reset = 0;
  endtask

  task automatic test_basic();
    logic exp_seq[$] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1};
    sel = 0; cl = 12; wq = '{8'hA5, 8'h3C};
    run(0, 0, -1, -1, -1);
    checks++;
    if (got != exp_seq) begin failures++; $display("FAIL basic_seq: got %p, required %p", got, exp_seq); end
    checks++;
    if (nrl != 4) begin failures++; $display("FAIL basic_clear: nreset low %0d cycles, required 4", nrl); end
    checks++;
    if (runs != '{8, 4}) begin failures++; $display("FAIL basic_enable_runs: %p, required '{8,4}", runs); end
    checks++;
    if (!o_done || o_busy || o_bc !== 16'd12 || o_en || !o_nrst || o_ready) begin
      failures++;
      $display("FAIL basic_done: done=%b busy=%b bc=%0d en=%b nrst=%b rdy=%b, required 1 0 12 0 1 0",
               o_done, o_busy, o_bc, o_en, o_nrst, o_ready);
    end
  endtask

  task automatic test_stall();
    sel = 0; cl = 12; fill();
    run(5, 0, -1, -1, -1);
    checks++;
    if (seq_errors() != 0) begin failures++; $display("FAIL stall_seq: got %p for words %p", got, wq); end
    checks++;
    if (runs != '{8, 4} || viol != 0) begin
      failures++; $display("FAIL stall_enable: runs %p data_when_idle=%0d, required '{8,4} and 0", runs, viol);
    end
  endtask

  task automatic test_abort();
    sel = 0; cl = 12; fill();
    run(1, 1, 3, -1, -1);
    checks++;
    if (o_en || o_busy || o_done || !o_nrst || o_bc !== 16'd3) begin
      failures++;
      $display("FAIL abort_state: en=%b busy=%b done=%b nrst=%b bc=%0d, required 0 0 0 1 3",
               o_en, o_busy, o_done, o_nrst, o_bc);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (o_busy || o_bc !== 16'd3) begin
      failures++; $display("FAIL abort_idle: busy=%b bc=%0d, required 0 3", o_busy, o_bc);
    end
    fill();
    run(2, 1, -1, -1, -1);
    checks++;
    if (seq_errors() != 0 || o_bc !== 16'd12 || !o_done) begin
      failures++; $display("FAIL abort_reload: got %p bc=%0d done=%b for words %p", got, o_bc, o_done, wq);
    end
  endtask

  task automatic test_start_busy();
    sel = 0; cl = 12; fill();
    run(1, 1, -1, 5, -1);
    checks++;
    if (seq_errors() != 0 || o_bc !== 16'd12 || !o_done || nrl != 4) begin
      failures++;
      $display("FAIL start_busy: got %p bc=%0d done=%b nrl=%0d, required model seq, 12, 1, 4", got, o_bc, o_done, nrl);
    end
  endtask

  task automatic test_reset_mid();
    sel = 0; cl = 12; fill();
    run(0, 0, -1, -1, 5);
    checks++;
    if ({o_ready, o_data, o_en, o_nrst, o_busy, o_done} !== 6'b000100 || o_bc !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid: rdy,dat,en,nrst,busy,done=%b bc=%0d, required 000100 bc=0",
               {o_ready, o_data, o_en, o_nrst, o_busy, o_done}, o_bc);
    end
    fill();
    run(3, 1, -1, -1, -1);
    checks++;
    if (seq_errors() != 0 || o_bc !== 16'd12) begin
      failures++; $display("FAIL reset_reload: got %p bc=%0d for words %p", got, o_bc, wq);
    end
  endtask

  task automatic test_random();
    sel = 0; cl = 12;
    for (int k = 0; k < 6; k++) begin
      fill();
      run(4, 1, -1, -1, -1);
      checks++;
      if (seq_errors() != 0 || o_bc !== 16'd12 || viol != 0 || rdy_after != 0) begin
        failures++;
        $display("FAIL random_load%0d: got %p bc=%0d viol=%0d extra_ready=%0d for words %p",
                 k, got, o_bc, viol, rdy_after, wq);
      end
    end
  endtask

  task automatic test_exact_multiple();
    sel = 1; cl = 16;
    for (int k = 0; k < 2; k++) begin
      fill();
      run(2, 1, -1, -1, -1);
      checks++;
      if (seq_errors() != 0 || runs != '{8, 8} || rdy_after != 0 || o_bc !== 16'd16 || !o_done) begin
        failures++;
        $display("FAIL exact_multiple%0d: got %p runs %p extra_ready=%0d bc=%0d done=%b",
                 k, got, runs, rdy_after, o_bc, o_done);
      end
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_start_busy();
    test_reset_mid();
    test_random();
    test_exact_multiple();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
